mdu_seq: RTL and testbench

- Multi-cycle unsigned multiply/divide sequencer for the beta-cpu execute stage.
- Does not contain its own adder. It drives the shared ALU through a dedicated operand/function port and reads back the combinational ALU result every iteration.
- Accepts one operation through a valid/ready request channel and returns the 32-bit result through a valid/ready response channel.

---
 rtl/mdu_seq.sv | 160 ++++++++++++++++
 tb/tb_mdu_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Multi-cycle unsigned multiply/divide sequencer.
// Borrows the shared execute-stage ALU for every add/subtract step.
module mdu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kill,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_div0,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fn,
  input  logic [31:0] alu_y
);

  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = $clog2(ITERS);
  localparam logic [5:0]  FN_ADD = 6'b010000;
  localparam logic [5:0]  FN_SUB = 6'b010001;

  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [1:0]       op, op_nxt;
  // acc_r: acc (MUL) or rem (DIV); opa_r: mcand or dvd; opb_r: mplier or divisor
  logic [31:0]      acc_r, acc_nxt;
  logic [31:0]      opa_r, opa_nxt;
  logic [31:0]      opb_r, opb_nxt;
  logic [31:0]      data_nxt;
  logic             div0_nxt;

  logic             op_is_div;
  logic             req_is_div;
  logic             hi;
  logic [31:0]      rs;
  logic             ge;

  assign req_ready  = (state == S_IDLE);
  assign op_is_div  = (op == OP_DIVU) || (op == OP_REMU);
  assign req_is_div = (req_op == OP_DIVU) || (req_op == OP_REMU);

  // Restoring-division step: 33-bit partial remainder is {hi, rs}
  assign hi = acc_r[31];
  assign rs = {acc_r[30:0], opa_r[31]};
  assign ge = hi | (rs >= opb_r);

  // ALU operand drive depends only on registered state
  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_fn = FN_ADD;
    if (state == S_RUN) begin
      if (op_is_div) begin
        alu_a  = rs;
        alu_b  = opb_r;
        alu_fn = FN_SUB;
      end else begin
        alu_a  = acc_r;
        alu_b  = opa_r;
        alu_fn = FN_ADD;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    op_nxt    = op;
    acc_nxt   = acc_r;
    opa_nxt   = opa_r;
    opb_nxt   = opb_r;
    data_nxt  = resp_data;
    div0_nxt  = resp_div0;

    case (state)
      S_IDLE: begin
        if (req_valid && !kill) begin
          op_nxt    = req_op;
          opa_nxt   = req_a;
          opb_nxt   = req_b;
          acc_nxt   = 32'd0;
          count_nxt = '0;
          if (req_is_div && (req_b == 32'd0)) begin
            state_nxt = S_DONE;
            div0_nxt  = 1'b1;
            data_nxt  = (req_op == OP_DIVU) ? 32'hFFFF_FFFF : req_a;
          end else begin
            state_nxt = S_RUN;
            div0_nxt  = 1'b0;
          end
        end
      end

      S_RUN: begin
        if (kill) begin
          state_nxt = S_IDLE;
        end else begin
          if (op_is_div) begin
            acc_nxt = ge ? alu_y : rs;
            opa_nxt = {opa_r[30:0], ge};
          end else begin
            if (opb_r[0]) acc_nxt = alu_y;
            opa_nxt = {opa_r[30:0], 1'b0};
            opb_nxt = {1'b0, opb_r[31:1]};
          end
          if (count == CNT_W'(ITERS - 1)) begin
            state_nxt = S_DONE;
            data_nxt  = (op == OP_DIVU) ? opa_nxt : acc_nxt;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        if (kill || resp_ready) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      op         <= 2'b00;
      acc_r      <= 32'd0;
      opa_r      <= 32'd0;
      opb_r      <= 32'd0;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      resp_div0  <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      op         <= op_nxt;
      acc_r      <= acc_nxt;
      opa_r      <= opa_nxt;
      opb_r      <= opb_nxt;
      resp_valid <= (state_nxt == S_DONE);
      resp_data  <= data_nxt;
      resp_div0  <= div0_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a behavioural model of the shared ALU.
module tb_mdu_seq;

  localparam logic [5:0] FN_ADD = 6'b010000;
  localparam logic [5:0] FN_SUB = 6'b010001;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kill;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_div0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fn;
  logic [31:0] alu_y;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Shared ALU stand-in
  assign alu_y = (alu_fn == FN_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

  mdu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kill       (kill),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_div0  (resp_div0),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fn     (alu_fn),
    .alu_y      (alu_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the response, check latency/result, then handshake
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data,
                        input logic exp_div0, input int exp_lat, input logic [5:0] exp_fn);
    int n;
    logic fn_ok;
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    n = 0;
    fn_ok = 1'b1;
    while (!resp_valid && n < 100) begin
      if (alu_fn !== exp_fn || req_ready !== 1'b0) fn_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (exp_lat > 0) check({tag, "_run_fn"}, 32'(fn_ok), 32'd1);
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_div0"}, 32'(resp_div0), 32'(exp_div0));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_drop"}, 32'({resp_valid, req_ready}), 32'b01);
  endtask

  initial begin
    int n;
    logic stable;
    logic saw_valid;

    rst_n      = 1'b0;
    kill       = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    tick();
    tick();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data",  resp_data, 32'd0);
    check("rst_resp_div0",  32'(resp_div0), 32'd0);
    check("rst_req_ready",  32'(req_ready), 32'd1);
    check("rst_alu_fn",     32'(alu_fn), 32'(FN_ADD));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Main function
    run_op("mul_7x6",   OP_MUL,  32'd7,          32'd6,          32'd42,         1'b0, 32, FN_ADD);
    run_op("mul_ffxff", OP_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 32, FN_ADD);
    run_op("mul_ovf",   OP_MUL,  32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  1'b0, 32, FN_ADD);
    run_op("mul_op11",  2'b11,   32'd12,         32'd11,         32'd132,        1'b0, 32, FN_ADD);
    run_op("divu_100",  OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0, 32, FN_SUB);
    run_op("remu_100",  OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0, 32, FN_SUB);
    run_op("divu_hi",   OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h0000_0001,  1'b0, 32, FN_SUB);
    run_op("remu_hi",   OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  1'b0, 32, FN_SUB);
    run_op("divu_0",    OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 0,  FN_ADD);
    run_op("remu_0",    OP_REMU, 32'd5,          32'd0,          32'd5,          1'b1, 0,  FN_ADD);
    run_op("divu_nz",   OP_DIVU, 32'd9,          32'd3,          32'd3,          1'b0, 32, FN_SUB);

    // Back-pressure: result held while resp_ready is low
    req_valid = 1'b1;
    req_op    = OP_MUL;
    req_a     = 32'd3;
    req_b     = 32'd5;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
    end
    check("hold_latency", 32'(n), 32'd32);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_data !== 32'd15 || req_ready !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("hold_release", 32'({resp_valid, req_ready}), 32'b01);

    // kill at count==10 during a divide
    req_valid = 1'b1;
    req_op    = OP_DIVU;
    req_a     = 32'd1000;
    req_b     = 32'd3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_idle", 32'({resp_valid, req_ready}), 32'b01);
    check("kill_data_kept", resp_data, 32'd15);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid !== 1'b0) saw_valid = 1'b1;
    end
    check("kill_no_resp", 32'(saw_valid), 32'd0);

    // kill in IDLE blocks acceptance
    kill      = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_MUL;
    req_a     = 32'd2;
    req_b     = 32'd2;
    tick();
    kill      = 1'b0;
    req_valid = 1'b0;
    check("kill_idle_block", 32'({req_ready, alu_fn}), 32'({1'b1, FN_ADD}));
    tick();
    check("kill_idle_nothing", 32'(resp_valid), 32'd0);

    // Async reset mid-RUN
    req_valid = 1'b1;
    req_op    = OP_MUL;
    req_a     = 32'd9;
    req_b     = 32'd9;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", 32'(req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_outputs", 32'({resp_valid, resp_div0}), 32'd0);
    check("arst_data", resp_data, 32'd0);
    check("arst_alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("post_rst", OP_REMU, 32'd17, 32'd5, 32'd2, 1'b0, 32, FN_SUB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
